nios_system_onchip_ram_pipe: RTL

Parametrised on-chip RAM presented as an Avalon-MM pipelined slave for the Nios II data/instruction masters. It generalises the 8-bit single-port RAM in data width, depth, byte-enable write merging and selectable read latency. It adds readdatavalid and waitrequest signalling, so the interconnect can issue back-to-back reads. Memory is inferred block RAM, optionally preloaded from INIT_FILE.

---
 rtl/nios_system_onchip_ram_pipe.sv | 98 +++++++++
 1 files changed

// File: rtl/nios_system_onchip_ram_pipe.sv
// Avalon-MM pipelined on-chip RAM: byte-enable writes, READ_LATENCY 1 or 2, one read per cycle.
// Latency: readdatavalid READ_LATENCY enabled cycles after an accepted read; writes land on the accept edge.
// Backpressure: waitrequest = ~(clken & ~reset_req); a freeze holds every stage and masks readdatavalid.
// Ports: clk/reset_n (async active-low), address/chipselect/read/write/byteenable/writedata command
// side, clken/reset_req freeze gates, waitrequest/readdata/readdatavalid response side.
module nios_system_onchip_ram_pipe #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 12,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "nios_system_onchip_ram_pipe.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic en;
  logic wr_acc;
  logic rd_acc;

  // Preload is handled by the device tool chain from the init file; reset never touches the array.
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // First read stage: registered RAM output plus its valid flag.
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;

  assign en          = clken & ~reset_req;
  assign waitrequest = ~en;
  assign wr_acc      = chipselect & write & en;
  // A simultaneous read+write performs only the write.
  assign rd_acc      = chipselect & read & ~write & en;

  // Array write, per byte lane. No reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) begin
          mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
    end
  end

  // Reads never coincide with writes, so a read accepted the cycle after a write
  // already sees the updated word. d1 only loads on a read, so it holds the last read value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (en) begin
      v1 <= rd_acc;
      if (rd_acc) begin
        d1 <= mem[address];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else if (en) begin
          v2 <= v1;
          if (v1) begin
            d2 <= d1;
          end
        end
      end

      // Masking with en keeps a frozen pending read from pulsing more than once.
      assign readdatavalid = v2 & en;
      assign readdata      = d2;
    end else begin : g_lat1
      assign readdatavalid = v1 & en;
      assign readdata      = d1;
    end
  endgenerate

endmodule
